// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: loads a parallel pattern, shifts it out MSB-first,
// repeats it with one-cycle gaps. Optional even-parity bit per frame via SEQ_GEN_PARITY_EN.
module seq_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       S
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // One spare LSB slot carries the parity bit right behind the last data bit.
  localparam int SRW = WIDTH + PAR;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    SHIFT = 3'b010,
    GAP   = 3'b011,
    DONE  = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic [SRW-1:0]   sr_q, sr_d;

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;
  logic [SRW-1:0]   frame_img;
  logic [LEN_W-1:0] bitcnt_init;

  assign len_eff = ((len == '0) || (len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : len;
  assign shamt   = LEN_W'(WIDTH) - len_q;
  // Left-aligning drops bits above len and leaves zeros below the frame.
  assign aligned = shadow_q << shamt;
  assign bitcnt_init = len_q - LEN_W'(1) + LEN_W'(PAR);

`ifdef SEQ_GEN_PARITY_EN
  assign frame_img = {aligned, 1'b0} | ({{(SRW-1){1'b0}}, ^aligned} << shamt);
`else
  assign frame_img = aligned;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      len_q    <= '0;
      bitcnt_q <= '0;
      rpt_q    <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      rpt_q    <= rpt_d;
      sr_q     <= sr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    len_d    = len_q;
    bitcnt_d = bitcnt_q;
    rpt_d    = rpt_q;
    sr_d     = sr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Request captured here so later input changes cannot touch the run.
          shadow_d = pattern;
          len_d    = len_eff;
          rpt_d    = repeat_cnt;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        sr_d     = frame_img;
        bitcnt_d = bitcnt_init;
        state_d  = SHIFT;
      end
      SHIFT: begin
        sr_d     = sr_q << 1;
        bitcnt_d = bitcnt_q - LEN_W'(1);
        if (bitcnt_q == '0)
          state_d = (rpt_q != '0) ? GAP : DONE;
      end
      GAP: begin
        sr_d     = frame_img;
        bitcnt_d = bitcnt_init;
        rpt_d    = rpt_q - CNT_W'(1);
        state_d  = SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == SHIFT);
    x     = valid & sr_q[SRW-1];
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    S     = state_q;
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed plus random requests checked cycle-by-cycle
// against a per-request expected trace built from the frame rules.
module tb_seq_pattern_gen;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] repeat_cnt;
  logic             x, valid, busy, done;
  logic [2:0]       S;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [2:0] s;
    logic       x;
    logic       v;
    logic       d;
  } cyc_t;

  seq_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt), .x(x), .valid(valid), .busy(busy), .done(done), .S(S)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input logic [2:0] es, input logic ex,
                         input logic ev, input logic eb, input logic ed);
    chk({tag, ".S"}, 32'(S), 32'(es));
    chk({tag, ".x"}, 32'(x), 32'(ex));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  // Expected trace: LOAD, then per frame its bits (plus parity), GAP between frames, DONE.
  task automatic run_req(input string tag, input logic [7:0] p, input int l, input int r,
                         input bit inject);
    cyc_t q[$];
    int   leff, busy_cnt, done_cnt;
    logic par, b;
    leff = (l == 0 || l > WIDTH) ? WIDTH : l;
    q.push_back('{3'd1, 1'b0, 1'b0, 1'b0});
    for (int f = 0; f <= r; f++) begin
      par = 1'b0;
      for (int i = 0; i < leff; i++) begin
        b = p[leff-1-i];
        par ^= b;
        q.push_back('{3'd2, b, 1'b1, 1'b0});
      end
`ifdef SEQ_GEN_PARITY_EN
      q.push_back('{3'd2, par, 1'b1, 1'b0});
`endif
      if (f < r) q.push_back('{3'd3, 1'b0, 1'b0, 1'b0});
    end
    q.push_back('{3'd4, 1'b0, 1'b0, 1'b1});

    pattern    = p;
    len        = 4'(l);
    repeat_cnt = 4'(r);
    start      = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    foreach (q[k]) begin
      chk_cyc($sformatf("%s.c%0d", tag, k), q[k].s, q[k].x, q[k].v, 1'b1, q[k].d);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      // Extra start requests while shifting must be ignored.
      start   = inject && (q[k].s == 3'd2);
      pattern = (inject && (q[k].s == 3'd2)) ? 8'hFF : p;
      tick();
    end
    start = 1'b0;
    chk_cyc({tag, ".idle"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".busy_len"}, 32'(busy_cnt), 32'(q.size()));
    chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b1; pattern = 8'hFF; len = 4'd4; repeat_cnt = 4'd0;
    tick();
    chk_cyc("rst0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_cyc("rst1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0; start = 1'b0;
    tick();
    chk_cyc("post_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_req("p06", 8'h06, 4, 0, 1'b0);
    run_req("pA5r2", 8'hA5, 0, 2, 1'b0);
    run_req("p06inj", 8'h06, 4, 0, 1'b1);
    run_req("p07", 8'h07, 4, 0, 1'b0);
    run_req("len_big", 8'h3C, 12, 1, 1'b0);
    run_req("len1", 8'h01, 1, 3, 1'b0);

    // Abort after the third bit of an A5 frame.
    pattern = 8'hA5; len = 4'd8; repeat_cnt = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_cyc("ab.load", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_cyc("ab.b0", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_cyc("ab.b1", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_cyc("ab.b2", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    RESET = 1'b1;
    tick();
    chk_cyc("ab.rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cyc($sformatf("ab.idle%0d", i), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_req("ab.again", 8'hA5, 8, 0, 1'b0);

    for (int t = 0; t < 20; t++)
      run_req($sformatf("rnd%0d", t), 8'($urandom_range(0, 255)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), bit'(t % 2));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
